// File: rtl/updown_mod_ctr.sv
// updown_mod_ctr: up/down counter over 0..limit with synchronous load, wrap pulse (tc) and one-shot halt.
// Optional build macro CTR_COMPARE_EN adds a registered count == cmp_value compare output.
module updown_mod_ctr #(
    parameter int WIDTH     = 10,
    parameter int RESET_VAL = 0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic             count_reversed,
    input  logic             oneshot,
    input  logic             load,
    input  logic [WIDTH-1:0] load_value,
    input  logic [WIDTH-1:0] limit,
`ifdef CTR_COMPARE_EN
    input  logic [WIDTH-1:0] cmp_value,
    output logic             cmp_match,
`endif
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             done
);

    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);
    localparam logic [WIDTH-1:0] RST_COUNT = WIDTH'(RESET_VAL);

    typedef enum logic {RUN, HALT} state_t;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            count <= RST_COUNT;
            tc    <= 1'b0;
        end else begin
            state <= state_nxt;
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

    // A count above a lowered limit is clamped on the next enabled edge; counting
    // down this is a plain step, counting up it is a wrap.
    always_comb begin
        state_nxt = state;
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = (load_value > limit) ? limit : load_value;
            state_nxt = RUN;
        end else if (enable && state == RUN) begin
            if (!count_reversed) begin
                if (count < limit) begin
                    count_nxt = count + ONE;
                end else begin
                    tc_nxt = 1'b1;
                    if (oneshot) begin
                        count_nxt = limit;
                        state_nxt = HALT;
                    end else begin
                        count_nxt = '0;
                    end
                end
            end else begin
                if (count > limit) begin
                    count_nxt = limit;
                end else if (count != '0) begin
                    count_nxt = count - ONE;
                end else begin
                    tc_nxt = 1'b1;
                    if (oneshot) begin
                        count_nxt = '0;
                        state_nxt = HALT;
                    end else begin
                        count_nxt = limit;
                    end
                end
            end
        end
    end

    assign done = (state == HALT);

`ifdef CTR_COMPARE_EN
    // Compared against the value count takes at this edge so the flag lines up with count.
    always_ff @(posedge clk) begin
        if (rst) cmp_match <= (RST_COUNT == cmp_value);
        else     cmp_match <= (count_nxt == cmp_value);
    end
`endif

endmodule

// File: doc/updown_mod_ctr.md
Name: updown_mod_ctr

Overview:
- Parametrised up/down counter with a programmable modulus limit, synchronous parallel load, a wrap/terminal-count pulse, and a one-shot mode.
- Successor to the team's fixed 10-bit up/down counter.
- Acts as a general timing/sequencing primitive in the datapath: free-running cycle counters, down-counting timeouts, and modulo-N address generators.
- All state lives in a single clock domain and is reset synchronously.

Parameters:
- WIDTH, 10, counter width in bits; legal range 2..32.
- RESET_VAL, 0, value of count after reset; must be <= the limit in use at reset release.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst  input  1  synchronous, active-high reset.
- enable  input  1  count-enable; when low, count holds.
- count_reversed  input  1  direction: 0 = count up, 1 = count down.
- oneshot  input  1  mode: 0 = free-run (wrap around), 1 = one-shot (halt at boundary).
- load  input  1  synchronous load strobe.
- load_value  input  WIDTH  value captured when load is high.
- limit  input  WIDTH  upper bound of the count range; range is 0..limit inclusive.
- count  output  WIDTH  current count, registered.
- tc  output  1  terminal-count pulse, registered.
- done  output  1  one-shot halted flag, registered.

Behaviour:
- Interface: one clock (clk); reset is synchronous and active-high (rst).
- Reset (rst=1 at a rising clk edge): count=RESET_VAL, tc=0, done=0, FSM=RUN. Reset overrides all other inputs.
- Priority at each edge: rst > load > enable. With enable=0 and no load, count holds, tc=0, done holds.
- Load:
  - count = min(load_value, limit); tc=0; done=0; FSM=RUN.
  - Applies even when enable=0 and even in HALT.
- Up count (enable=1, count_reversed=0, FSM=RUN):
  - If count < limit: count+1.
  - If count >= limit, this is a wrap event.
- Down count (enable=1, count_reversed=1, FSM=RUN):
  - If 0 < count <= limit: count-1.
  - If count > limit (limit lowered while running): count = limit, not a wrap event.
  - If count == 0, this is a wrap event.
- Wrap event, free-run (oneshot=0):
  - Up: count=0. Down: count=limit.
  - tc=1 for exactly the one cycle in which count shows the post-wrap value.
- Wrap event, one-shot (oneshot=1):
  - count holds its boundary value: limit when counting up, 0 when counting down. If count > limit when counting up, count = limit.
  - FSM goes to HALT, done=1, tc=1 for one cycle.
- FSM states and transitions:
  - RUN -> HALT on a one-shot wrap event.
  - HALT -> RUN on load or rst only.
  - In HALT, enable and direction are ignored; count and done hold; tc=0.
  - Clearing oneshot while in HALT does not leave HALT.
- Direction or oneshot changes take effect at the next enabled edge; there is no pipeline.
- limit=0: count stays 0 and every enabled RUN cycle is a wrap event. In free-run, tc stays high continuously.
- Arithmetic is unsigned, modulo 2^WIDTH internally. No output exceeds limit after the first enabled edge or load.
- No combinational path from inputs to any output.

Optional Feature:
- Macro: CTR_COMPARE_EN.
- Defined:
  - Adds port cmp_value (input, WIDTH): compare value.
  - Adds port cmp_match (output, 1): registered; high in every cycle where count == cmp_value, evaluated against the registered count.
  - cmp_match resets to (RESET_VAL == cmp_value at the reset edge).
- Undefined: cmp_value and cmp_match ports are absent; no compare logic is synthesised.

Test Plan:
- Free-run up: WIDTH=10, limit=9, rst then enable=1 for 12 cycles -> count 0,1,…,9,0,1,2; tc=1 only in the cycle count returns to 0.
- Free-run down with live limit change: limit=9, load 3, count_reversed=1 -> count 3,2,1,0,9,8; tc=1 in the cycle count=9. Then drop limit to 5 while count=8 -> next count 5, tc=0.
- One-shot down timeout: oneshot=1, load 4, count_reversed=1 -> count 3,2,1,0; at the edge after 0, done=1 and tc pulses one cycle. Count stays 0 for 10 further enabled cycles. A load of 7 clears done and resumes counting 6,5.
- Priority and hold: enable=0 for 5 cycles -> count unchanged. load=1 together with enable=1 and load_value=1023, limit=9 -> count=9. rst=1 together with load=1 -> count=RESET_VAL, done=0.
- Edge limit: limit=0, free-run, enable=1 for 4 cycles -> count=0 and tc=1 on each. Same with oneshot=1 -> done=1 after the first edge, tc single pulse.
- CTR_COMPARE_EN build: cmp_value=5, limit=9, up count from 0 -> cmp_match=1 only while count=5, every wrap period. Undefined build elaborates without the cmp ports.
